// File: rtl/conv_layer_sched.sv
// Layer sequencer for the 3x3 convolve engine: one start per two-output tile.
// Optional perf counters (perf_cycles, perf_stall) are built when CONV_SCHED_PERF_EN is defined.
module conv_layer_sched #(
  parameter int ADDR_W = 5,
  parameter int DIM_W  = 6,
  parameter int CNT_W  = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [DIM_W-1:0]  cfg_rows,
  input  logic [DIM_W-1:0]  cfg_cols,
  input  logic [1:0]        cfg_stride,
  input  logic [ADDR_W-1:0] cfg_base,
  input  logic              abort,
  output logic              conv_start,
  output logic [1:0]        conv_stride,
  output logic [ADDR_W-1:0] conv_dest_addr,
  input  logic              conv_done,
  output logic              busy,
  output logic              layer_done,
  output logic              cfg_err,
  output logic [CNT_W-1:0]  tile_count,
  output logic [2:0]        dbg_state
`ifdef CONV_SCHED_PERF_EN
  ,
  output logic [31:0]       perf_cycles,
  output logic [15:0]       perf_stall
`endif
);

  localparam int GW = DIM_W + 1;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ISSUE   = 3'd1,
    S_WAIT    = 3'd2,
    S_ADVANCE = 3'd3,
    S_FINISH  = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic                cfg_ready_q, cfg_ready_d;
  logic                conv_start_q, conv_start_d;
  logic [1:0]          stride_q, stride_d;
  logic [ADDR_W-1:0]   dest_q, dest_d;
  logic                busy_q, busy_d;
  logic                layer_done_q, layer_done_d;
  logic                cfg_err_q, cfg_err_d;
  logic [CNT_W-1:0]    tile_count_q, tile_count_d;
  logic [CNT_W-1:0]    total_q, total_d;
  logic                done_prev_q, done_prev_d;

  logic [GW-1:0]       rows_m3, cols_m3, out_rows, out_cols, tiles_per_row;
  logic [2*GW-1:0]     geo_prod;
  logic [CNT_W-1:0]    geo_total;
  logic                cfg_legal, accept, done_rise;

  // Descriptor handshake: a descriptor transfers on the rising clk edge where
  // cfg_valid && cfg_ready; cfg_ready is high only in IDLE and abort blocks the transfer.
  always_comb begin
    rows_m3       = {1'b0, cfg_rows} - GW'(3);
    cols_m3       = {1'b0, cfg_cols} - GW'(3);
    // stride is 1 or 2 when legal, so stride-1 is just bit 1
    out_rows      = (rows_m3 >> cfg_stride[1]) + GW'(1);
    out_cols      = (cols_m3 >> cfg_stride[1]) + GW'(1);
    tiles_per_row = (out_cols + GW'(1)) >> 1;
    geo_prod      = {{GW{1'b0}}, out_rows} * {{GW{1'b0}}, tiles_per_row};
    geo_total     = CNT_W'(geo_prod);
    cfg_legal     = (cfg_rows >= DIM_W'(3)) && (cfg_cols >= DIM_W'(3)) &&
                    ((cfg_stride == 2'd1) || (cfg_stride == 2'd2));
    accept        = (state_q == S_IDLE) && cfg_valid && !abort;
    done_rise     = conv_done && !done_prev_q;

    state_d       = state_q;
    stride_d      = stride_q;
    dest_d        = dest_q;
    tile_count_d  = tile_count_q;
    total_d       = total_q;
    cfg_err_d     = 1'b0;
    done_prev_d   = conv_done;

    if (abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            if (cfg_legal) begin
              state_d      = S_ISSUE;
              stride_d     = cfg_stride;
              dest_d       = cfg_base;
              tile_count_d = '0;
              total_d      = geo_total;
            end else begin
              cfg_err_d = 1'b1;
            end
          end
        end
        S_ISSUE: state_d = S_WAIT;
        S_WAIT: begin
          if (done_rise) begin
            state_d      = S_ADVANCE;
            tile_count_d = tile_count_q + CNT_W'(1);
            dest_d       = dest_q + ADDR_W'(2);
          end
        end
        S_ADVANCE: begin
          // let the engine drop done before restarting it
          if (tile_count_q == total_q) state_d = S_FINISH;
          else if (!conv_done)         state_d = S_ISSUE;
        end
        S_FINISH: state_d = S_IDLE;
        default:  state_d = S_IDLE;
      endcase
    end

    cfg_ready_d  = (state_d == S_IDLE);
    conv_start_d = (state_d == S_ISSUE);
    busy_d       = (state_d == S_ISSUE) || (state_d == S_WAIT) || (state_d == S_ADVANCE);
    layer_done_d = (state_d == S_FINISH);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cfg_ready_q  <= 1'b1;
      conv_start_q <= 1'b0;
      stride_q     <= 2'd1;
      dest_q       <= '0;
      busy_q       <= 1'b0;
      layer_done_q <= 1'b0;
      cfg_err_q    <= 1'b0;
      tile_count_q <= '0;
      total_q      <= '0;
      done_prev_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cfg_ready_q  <= cfg_ready_d;
      conv_start_q <= conv_start_d;
      stride_q     <= stride_d;
      dest_q       <= dest_d;
      busy_q       <= busy_d;
      layer_done_q <= layer_done_d;
      cfg_err_q    <= cfg_err_d;
      tile_count_q <= tile_count_d;
      total_q      <= total_d;
      done_prev_q  <= done_prev_d;
    end
  end

  assign cfg_ready      = cfg_ready_q;
  assign conv_start     = conv_start_q;
  assign conv_stride    = stride_q;
  assign conv_dest_addr = dest_q;
  assign busy           = busy_q;
  assign layer_done     = layer_done_q;
  assign cfg_err        = cfg_err_q;
  assign tile_count     = tile_count_q;
  assign dbg_state      = state_q;

`ifdef CONV_SCHED_PERF_EN
  logic [31:0] perf_cycles_q, perf_cycles_d;
  logic [15:0] perf_stall_q, perf_stall_d;

  always_comb begin
    perf_cycles_d = perf_cycles_q;
    perf_stall_d  = perf_stall_q;
    if (accept && cfg_legal) begin
      perf_cycles_d = '0;
      perf_stall_d  = '0;
    end else begin
      if (busy_q && (perf_cycles_q != '1)) perf_cycles_d = perf_cycles_q + 32'd1;
      if ((state_q == S_ADVANCE) && !abort && (tile_count_q != total_q) && conv_done &&
          (perf_stall_q != '1))
        perf_stall_d = perf_stall_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_cycles_q <= '0;
      perf_stall_q  <= '0;
    end else begin
      perf_cycles_q <= perf_cycles_d;
      perf_stall_q  <= perf_stall_d;
    end
  end

  assign perf_cycles = perf_cycles_q;
  assign perf_stall  = perf_stall_q;
`endif

endmodule

// File: doc/conv_layer_sched.md
Name: conv_layer_sched

Overview:
- Layer-level sequencer for the 3x3 convolve engine.
- Accepts one layer descriptor from the host: input rows/cols, stride and destination base address.
- Derives output geometry, then issues one convolve start per output tile. A tile is the 2 adjacent outputs (sum1/sum2) the engine writes at dest and dest+1.
- Sits between the host/command block and the convolve engine; owns engine start, stride and destination-address sequencing.

Parameters:
- ADDR_W, 5, width of destination address (matches engine in_dest_addr).
- DIM_W, 6, width of row/column dimension fields.
- CNT_W, 12, width of tile counter / tile_count output.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- cfg_valid  in  1  descriptor valid.
- cfg_ready  out  1  scheduler can accept descriptor.
- cfg_rows  in  DIM_W  input feature-map rows.
- cfg_cols  in  DIM_W  input feature-map columns.
- cfg_stride  in  2  convolution stride (1 or 2 legal).
- cfg_base  in  ADDR_W  destination base address.
- abort  in  1  synchronous abort of current layer.
- conv_start  out  1  one-cycle start pulse to engine.
- conv_stride  out  2  stride to engine, held stable while busy.
- conv_dest_addr  out  ADDR_W  engine in_dest_addr, stable from conv_start until the done edge.
- conv_done  in  1  engine done (level; may stay high several cycles).
- busy  out  1  layer in progress.
- layer_done  out  1  one-cycle pulse when last tile completes.
- cfg_err  out  1  one-cycle pulse on rejected descriptor.
- tile_count  out  CNT_W  tiles completed in current/last layer.

Behaviour:
- Reset values: cfg_ready=1, conv_start=0, conv_stride=1, conv_dest_addr=0, busy=0, layer_done=0, cfg_err=0, tile_count=0, state=IDLE.
- Handshake: descriptor accepted on clk edge with cfg_valid && cfg_ready. cfg_ready=1 only in IDLE.
- Legality check at accept:
  - Reject if rows<3, cols<3, or stride not in {1,2}.
  - Reject: cfg_err pulses the next cycle; state stays IDLE; tile_count unchanged.
- Geometry, registered at accept; shift only, no divider:
  - out_rows = ((rows-3) >> (stride-1)) + 1
  - out_cols = ((cols-3) >> (stride-1)) + 1
  - tiles_per_row = (out_cols+1) >> 1
  - total = out_rows * tiles_per_row
- States:
  - IDLE: accept descriptor → ISSUE. On accept: tile_count=0, dest=cfg_base, busy=1 from next cycle.
  - ISSUE: conv_start=1 for exactly this cycle → WAIT. conv_start is high the cycle after accept.
  - WAIT: detect rising edge of conv_done (registered previous value) → ADVANCE. Levels already high on entry are not edges.
  - ADVANCE: tile_count+=1; dest+=2, modulo 2^ADDR_W. If tile_count+1==total → FINISH. Else hold until conv_done==0, then ISSUE. This lets the engine return to its idle state before the next start.
  - FINISH: layer_done=1 for one cycle, busy=0 → IDLE.
- Odd out_cols: last tile of each row still issued. Its second output lands at dest+1 and is don't-care for the consumer.
- Destination layout is dense and sequential; row boundaries do not skip addresses.
- conv_done edges outside WAIT are ignored; no count change.
- abort: any state → IDLE on next edge. conv_start forced 0, busy=0, no layer_done, tile_count frozen. abort in IDLE has no effect. abort and cfg_valid together in IDLE: abort wins, nothing accepted.
- conv_stride and conv_dest_addr are registered; they change only at accept/ADVANCE.

Optional Feature:
- Macro CONV_SCHED_PERF_EN.
- Defined: adds output perf_cycles [31:0]. It counts cycles with busy=1, clears at descriptor accept, holds after FINISH/abort, and saturates at 0xFFFFFFFF. It also adds output perf_stall [15:0], counting ADVANCE cycles spent waiting for conv_done low, with the same clearing and saturation rules.
- Undefined: ports and counters absent; all other behaviour identical.

Test Plan:
- rows=5, cols=5, stride=1, base=4; engine model asserts done 12 cycles after start for 2 cycles → 6 starts, dest 4,6,8,10,12,14; tile_count=6; one layer_done pulse; busy low after.
- rows=7, cols=7, stride=2, base=0 → out 3x3, tiles_per_row=2; 6 starts, dest 0..10 step 2; conv_stride=2 throughout.
- base=30, rows=3, cols=8, stride=1 → out_cols=6, 3 tiles; dest 30,0,2 (wrap); layer_done after 3rd done edge.
- Descriptors rows=2 / stride=0 / stride=3 → cfg_err pulse each, no conv_start, cfg_ready stays 1, tile_count unchanged.
- abort asserted in WAIT after 2 tiles of the 5x5 case → busy=0 next cycle, tile_count=2, no layer_done. A subsequent valid descriptor runs normally from tile_count=0.
- conv_done held high 20 cycles after a tile → exactly one count. Next conv_start only after conv_done falls. Reset asserted mid-layer → all outputs return to reset values asynchronously.
